cbd_poly_sched: RTL and testbench

- Sequences the eta=2 centered-binomial sampler datapath to produce 1 to 4 complete 256-coefficient polynomials.
- Pulls 64-bit PRF words over a valid/ready handshake and latches each word for the sampler.
- Drains the sampler's 16 raw coefficients as four 4-coefficient writes into coefficient RAM, reduced to [0, Q-1].
- Sits between the PRF/Keccak output buffer and the polynomial RAM feeding NTT.

---
 rtl/cbd_poly_sched_if.sv | 24 ++
 rtl/cbd_poly_sched.sv | 148 ++++++++++++++
 tb/tb_cbd_poly_sched.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/cbd_poly_sched_if.sv
// Handshake bundle for the CBD polynomial scheduler:
// PRF word input, sampler word/result, and coefficient RAM writes.
interface cbd_poly_sched_if;
  logic [63:0]  word_in;
  logic         word_valid;
  logic         word_ready;
  logic [63:0]  samp_word;
  logic [191:0] samp_coef;
  logic         coef_wr_en;
  logic [7:0]   coef_wr_addr;
  logic [47:0]  coef_wr_data;

  modport master (
    input  word_in, word_valid, samp_coef,
    output word_ready, samp_word,
    output coef_wr_en, coef_wr_addr, coef_wr_data
  );

  modport slave (
    output word_in, word_valid, samp_coef,
    input  word_ready, samp_word,
    input  coef_wr_en, coef_wr_addr, coef_wr_data
  );
endinterface

// File: rtl/cbd_poly_sched.sv
// Sequences the eta=2 CBD sampler: fetch one PRF word, then drain
// its 16 coefficients as four reduced 4-coefficient RAM writes.
module cbd_poly_sched #(
  parameter int Q              = 3329,
  parameter int COEF_W         = 12,
  parameter int WORDS_PER_POLY = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] num_poly,
  output logic       busy,
  output logic       done,
  output logic       err,
  cbd_poly_sched_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int LANE_W = 4 * COEF_W;
  // Negative raw r maps to r + Q, i.e. r - (2^COEF_W - Q) mod 2^COEF_W.
  localparam logic [COEF_W-1:0] NEG_OFS =
    COEF_W'((1 << COEF_W) - Q);
  localparam logic [COEF_W-1:0] MINUS2 =
    COEF_W'((1 << COEF_W) - 2);
  localparam logic [3:0] LAST_WORD = 4'(WORDS_PER_POLY - 1);

  logic [1:0]  state_q, state_d;
  logic [2:0]  num_q, num_d;
  logic [2:0]  poly_q, poly_d;
  logic [3:0]  word_q, word_d;
  logic [5:0]  grp_q, grp_d;
  logic [1:0]  lane_q, lane_d;
  logic [63:0] samp_q, samp_d;
  logic        err_q, err_d;

  logic [LANE_W-1:0] lane_w;
  logic [LANE_W-1:0] red;
  logic              bad;
  logic [2:0]        poly_inc;

  assign lane_w   = bus.samp_coef[LANE_W*lane_q +: LANE_W];
  assign poly_inc = poly_q + 3'd1;

  // Reduce the selected lane into [0, Q-1] and flag out-of-range samples.
  always_comb begin : reduce
    logic [COEF_W-1:0] raw;
    raw = '0;
    red = '0;
    bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      raw = lane_w[COEF_W*k +: COEF_W];
      red[COEF_W*k +: COEF_W] =
        raw[COEF_W-1] ? raw - NEG_OFS : raw;
      bad = bad | ((raw > COEF_W'(2)) && (raw < MINUS2));
    end
  end

  // Job sequencing: word fetch, four lane writes, poly/word counting.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    poly_d  = poly_q;
    word_d  = word_q;
    grp_d   = grp_q;
    lane_d  = lane_q;
    samp_d  = samp_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (num_poly == 3'd0) begin
            state_d = S_DONE;
          end else begin
            num_d   = (num_poly > 3'd4) ? 3'd4 : num_poly;
            poly_d  = '0;
            word_d  = '0;
            grp_d   = '0;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (bus.word_valid) begin
          samp_d  = bus.word_in;
          lane_d  = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        grp_d  = grp_q + 6'd1;
        lane_d = lane_q + 2'd1;
        if (bad) err_d = 1'b1;
        if (lane_q == 2'd3) begin
          state_d = S_FETCH;
          if (word_q == LAST_WORD) begin
            word_d = '0;
            grp_d  = '0;
            poly_d = poly_inc;
            if (poly_inc == num_q) state_d = S_DONE;
          end else begin
            word_d = word_q + 4'd1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      num_q   <= '0;
      poly_q  <= '0;
      word_q  <= '0;
      grp_q   <= '0;
      lane_q  <= '0;
      samp_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      poly_q  <= poly_d;
      word_q  <= word_d;
      grp_q   <= grp_d;
      lane_q  <= lane_d;
      samp_q  <= samp_d;
      err_q   <= err_d;
    end
  end

  assign busy   = (state_q == S_FETCH) || (state_q == S_WRITE);
  assign done   = (state_q == S_DONE);
  assign err    = err_q;

  assign bus.word_ready   = (state_q == S_FETCH);
  assign bus.samp_word    = samp_q;
  assign bus.coef_wr_en   = (state_q == S_WRITE);
  assign bus.coef_wr_addr = {poly_q[1:0], grp_q};
  assign bus.coef_wr_data = bus.coef_wr_en ? red : '0;

endmodule

// File: tb/tb_cbd_poly_sched.sv
// Scoreboard bench for cbd_poly_sched: a behavioural CBD sampler,
// expected RAM writes queued on each accepted PRF word.
module tb_cbd_poly_sched;
  localparam int Q = 3329;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] num_poly;
  logic       busy, done, err;
  logic       inject = 1'b0;

  cbd_poly_sched_if bus ();

  cbd_poly_sched dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .num_poly (num_poly),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  addr;
    logic [47:0] data;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  logic [7:0] exp_addr = '0;
  int         wr_cnt = 0;
  int         done_cnt = 0;
  int         vec_cnt = 0;
  int         miss_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int cbd(input logic [3:0] n);
    return int'(n[0]) + int'(n[1]) - int'(n[2]) - int'(n[3]);
  endfunction

  function automatic logic [47:0] exp_data(input logic [63:0] w,
                                           input int j,
                                           input logic inj);
    logic [47:0] d;
    int v;
    d = '0;
    for (int k = 0; k < 4; k++) begin
      v = cbd(w[16*j+4*k +: 4]);
      if (inj && j == 0 && k == 0) v = 5;
      if (v < 0) v = v + Q;
      d[12*k +: 12] = 12'(v);
    end
    return d;
  endfunction

  always_comb begin
    bus.samp_coef = '0;
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 4; k++)
        bus.samp_coef[48*j+12*k +: 12] =
          12'(cbd(bus.samp_word[16*j+4*k +: 4]));
    if (inject) bus.samp_coef[11:0] = 12'h005;
  end

  always @(negedge clk) begin
    if (bus.word_valid && bus.word_ready) begin
      for (int j = 0; j < 4; j++) begin
        exp_q.push_back(wr_t'({exp_addr,
                               exp_data(bus.word_in, j, inject)}));
        exp_addr = exp_addr + 8'd1;
      end
    end
    if (bus.coef_wr_en) begin
      wr_cnt++;
      chk("wr_while_ready", bus.word_ready, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_wr", bus.coef_wr_en, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", bus.coef_wr_addr, mon_e.addr);
        chk("wr_data", bus.coef_wr_data, mon_e.data);
      end
    end
    if (done) begin
      done_cnt++;
      chk("busy_at_done", busy, 0);
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_ready"}, bus.word_ready, 0);
    chk({tag, "_wren"}, bus.coef_wr_en, 0);
    chk({tag, "_addr"}, bus.coef_wr_addr, 0);
    chk({tag, "_data"}, bus.coef_wr_data, 0);
    chk({tag, "_sword"}, bus.samp_word, 0);
  endtask

  function automatic logic [63:0] next_word(input logic [63:0] pat,
                                            input bit rnd);
    return rnd ? {$urandom, $urandom} : pat;
  endfunction

  task automatic run_job(input logic [2:0] n, input logic [63:0] pat,
                         input bit rnd, input bit toggle,
                         input int exp_writes, input int kill_at);
    int cyc;
    bit acc;
    exp_q.delete();
    exp_addr = '0;
    wr_cnt   = 0;
    done_cnt = 0;
    @(posedge clk); #1;
    start          = 1'b1;
    num_poly       = n;
    bus.word_in    = next_word(pat, rnd);
    bus.word_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    if (n == 3'd0) begin
      chk("done_after_start", done, 1);
      chk("n0_ready", bus.word_ready, 0);
    end else begin
      chk("busy_after_start", busy, 1);
    end
    cyc = 0;
    while (!done && cyc < 5000 &&
           !(kill_at > 0 && wr_cnt >= kill_at)) begin
      acc = bus.word_valid && bus.word_ready;
      @(posedge clk); #1;
      if (acc) bus.word_in = next_word(pat, rnd);
      if (toggle) bus.word_valid = ~bus.word_valid;
      @(negedge clk);
      cyc++;
    end
    if (kill_at > 0) begin
      chk("kill_reached", wr_cnt >= kill_at, 1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_zero("rst_mid");
      @(posedge clk); #1;
      reset = 1'b0;
      chk("no_done_after_rst", done_cnt, 0);
      exp_q.delete();
    end else begin
      chk("job_done_seen", done, 1);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("busy_after_done", busy, 0);
      chk("write_count", wr_cnt, exp_writes);
      chk("done_count", done_cnt, 1);
      chk("queue_empty", exp_q.size(), 0);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    start          = 1'b0;
    num_poly       = '0;
    bus.word_in    = '0;
    bus.word_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("rst");
    @(posedge clk); #1;
    reset = 1'b0;

    run_job(3'd1, 64'h0, 1'b0, 1'b0, 64, 0);
    chk("err_zero_word", err, 0);
    run_job(3'd1, 64'h3, 1'b0, 1'b0, 64, 0);
    chk("err_plus2", err, 0);
    run_job(3'd1, 64'hC, 1'b0, 1'b0, 64, 0);
    chk("err_minus2", err, 0);
    run_job(3'd3, 64'h0, 1'b1, 1'b1, 192, 0);
    chk("err_rand3", err, 0);

    inject = 1'b1;
    run_job(3'd1, 64'h0, 1'b1, 1'b0, 64, 0);
    inject = 1'b0;
    chk("err_set", err, 1);
    repeat (3) @(negedge clk);
    chk("err_sticky", err, 1);

    run_job(3'd0, 64'h0, 1'b0, 1'b0, 0, 0);
    run_job(3'd7, 64'h0, 1'b1, 1'b0, 256, 0);
    chk("err_clr_start", err, 0);

    run_job(3'd2, 64'h0, 1'b1, 1'b0, 0, 10);
    run_job(3'd1, 64'h0, 1'b1, 1'b1, 64, 0);
    chk("err_after_rst", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_cnt, miss_cnt);
    $finish;
  end
endmodule
